// File: rtl/mccoy_prog_feeder.sv
// Program loader and instruction feeder for the McCoy core: captures a program
// word stream into local memory, then serves instructions by PC while holding the core in reset until primed.
module mccoy_prog_feeder #(
  parameter int unsigned DEPTH = 64,
  parameter logic [5:0]  FILL  = 6'b000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [5:0] load_data,
  output logic       load_ready,
  input  logic       load_done,
  input  logic [5:0] pc_in,
  output logic [5:0] instr_out,
  output logic       core_reset,
  output logic [6:0] prog_len,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, PRIME, RUN} state_t;

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  state_t     state_q, state_d;
  logic [6:0] prog_len_q, prog_len_d;
  logic [6:0] wptr_q, wptr_d;
  logic       overflow_q, overflow_d;
  logic [5:0] instr_q, instr_d;
  logic       core_reset_q, core_reset_d;
  logic       mem_we;
  logic [5:0] mem [DEPTH];

  assign load_ready = (state_q == LOAD) && (prog_len_q < DEPTH_W);
  assign running    = (state_q == RUN);
  assign instr_out  = instr_q;
  assign core_reset = core_reset_q;
  assign prog_len   = prog_len_q;
  assign overflow   = overflow_q;

  // load_start overrides everything else, including a simultaneous load_done.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    wptr_d     = wptr_q;
    overflow_d = overflow_q;
    instr_d    = FILL;
    mem_we     = 1'b0;
    if (load_start) begin
      state_d    = LOAD;
      prog_len_d = 7'd0;
      wptr_d     = 7'd0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        LOAD: begin
          if (load_valid) begin
            if (load_ready && !wptr_q[6]) begin
              mem_we     = 1'b1;
              wptr_d     = wptr_q + 7'd1;
              prog_len_d = prog_len_q + 7'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (load_done) state_d = PRIME;
        end
        PRIME: begin
          instr_d = (prog_len_q != 7'd0) ? mem[0] : FILL;
          state_d = RUN;
        end
        RUN: instr_d = ({1'b0, pc_in} < prog_len_q) ? mem[pc_in] : FILL;
        default: state_d = IDLE;
      endcase
    end
    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      prog_len_q   <= 7'd0;
      wptr_q       <= 7'd0;
      overflow_q   <= 1'b0;
      instr_q      <= FILL;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      wptr_q       <= wptr_d;
      overflow_q   <= overflow_d;
      instr_q      <= instr_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Program memory keeps its contents across reset and reloads.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[5:0]] <= load_data;
  end

endmodule

// File: doc/mccoy_prog_feeder.md
MCCOY_PROG_FEEDER -- requirements
Module: mccoy_prog_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 6-bit program words; the full 6-bit PC space.
REQ-002 SHALL have parameter FILL, default 6'b000000: instruction driven for addresses at or beyond the loaded program length.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_start  input  1  pulse; clears the program and enters LOAD.
REQ-006 load_valid  input  1  load_data holds a valid word.
REQ-007 load_data  input  6  program word: [2:0] opcode, [5:3] reg/imm.
REQ-008 load_ready  output  1  block accepts a word this cycle.
REQ-009 load_done  input  1  pulse; ends LOAD and enters RUN.
REQ-010 pc_in  input  6  PC value sampled from the McCoy core output on the rising edge.
REQ-011 instr_out  output  6  instruction presented to the core's instr inputs.
REQ-012 core_reset  output  1  active-high reset to the core.
REQ-013 prog_len  output  7  number of words loaded, 0..DEPTH.
REQ-014 running  output  1  high in RUN.
REQ-015 overflow  output  1  sticky; a word was offered while memory was full.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, PRIME and RUN; encoding is free.
REQ-017 IDLE SHALL go to LOAD on load_start; otherwise it holds.
REQ-018 On entering LOAD, prog_len, the write pointer and overflow SHALL clear; memory contents need not clear.
REQ-019 In LOAD, load_ready SHALL be 1 while prog_len < DEPTH, else 0.
REQ-020 On load_valid && load_ready, the block SHALL write load_data to mem[wptr], then increment wptr and prog_len.
REQ-021 On load_valid && !load_ready in LOAD, the block SHALL set overflow, drop the word and leave wptr unchanged (no wrap).
REQ-022 load_done in LOAD SHALL go to PRIME; if load_valid is accepted in the same cycle, that word SHALL be written first.
REQ-023 PRIME SHALL last exactly 1 cycle, then go to RUN.
REQ-024 core_reset SHALL be 1 in IDLE, LOAD and PRIME, and 0 in RUN.
REQ-025 In RUN, instr_out SHALL be registered: 1 cycle after sampling pc_in=p it equals mem[p] if p < prog_len, else FILL.
REQ-026 In PRIME, instr_out SHALL be loaded with mem[0] (FILL if prog_len=0), so that the core's first fetch after leaving reset is valid.
REQ-027 Outside PRIME and RUN, instr_out SHALL be FILL.
REQ-028 load_start in any state, including RUN and PRIME, SHALL abort and go to LOAD; core_reset SHALL reassert in that same cycle.
REQ-029 If load_start and load_done arrive together, load_start SHALL win.
REQ-030 pc_in SHALL be compared as unsigned 6-bit against the 7-bit prog_len, so pc 63 with prog_len 64 is in range.
REQ-031 load_ready and running SHALL be combinational decodes of the registered state.

Reset
REQ-032 Asserting reset (low) SHALL immediately force: state IDLE, prog_len 0, wptr 0, overflow 0, instr_out FILL, core_reset 1, running 0, load_ready 0.
REQ-033 Deasserting reset SHALL take effect synchronously on the next rising edge.
REQ-034 Memory array contents SHALL be unaffected by reset.

Verification
REQ-035 Load 3 words 0x0A, 0x11, 0x3F and pulse load_done -> prog_len=3; core_reset falls 2 cycles after load_done; instr_out=0x0A in the first RUN cycle.
REQ-036 In RUN with prog_len=3, drive pc_in 0,1,2,3,5 -> instr_out 0x0A, 0x11, 0x3F, FILL, FILL, each 1 cycle after its PC.
REQ-037 Offer 65 words -> 64 accepted, load_ready=0 after the 64th, overflow=1, prog_len=64; pc_in=63 -> mem[63].
REQ-038 Pulse load_start mid-RUN -> core_reset=1 and instr_out=FILL next cycle, prog_len=0, load_ready=1.
REQ-039 Pull reset low asynchronously mid-LOAD between clock edges -> all outputs take reset values before the next edge; a later load_done is ignored (IDLE).
REQ-040 Pulse load_done with prog_len=0 -> RUN with instr_out=FILL for every pc_in.
